// File: rtl/sp_ram_burst_master.sv
// Burst initiator for a single-port SRAM: one command becomes back-to-back word accesses.
// Writes are fed from a valid/ready stream; reads return through a small credit-controlled FIFO.
module sp_ram_burst_master #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 12,
    parameter int RD_BUF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_bypass_en_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;
    localparam int CNT_W    = $clog2(RD_BUF_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BE_WIDTH - 1));
    localparam logic [CNT_W:0]        DEPTH_OCC  = (CNT_W + 1)'(RD_BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RD_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    beats_q, beats_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [BE_WIDTH-1:0]     ram_be_q, ram_be_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    ram_last_q, ram_last_d;
    logic                    cap_vld_q;
    logic                    cap_last_q;

    logic [DATA_WIDTH:0]     fifo_mem [RD_BUF_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    push, pop, head_last, can_issue;
    logic [1:0]              pending;
    logic [CNT_W:0]          occ;

    // Reads in flight: one in the RAM request cycle, one whose data is on ram_rdata_i now.
    assign pending   = {1'b0, ram_en_q & ~ram_we_q} + {1'b0, cap_vld_q};
    assign occ       = {1'b0, count_q} + (CNT_W + 1)'(pending);
    assign can_issue = (beats_q != '0) && (occ < DEPTH_OCC);

    assign push       = cap_vld_q;
    assign pop        = rd_valid_o & rd_ready_i;
    assign head_last  = fifo_mem[rptr_q][DATA_WIDTH];
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = fifo_mem[rptr_q][DATA_WIDTH-1:0];
    assign rd_last_o  = rd_valid_o & head_last;

    assign ram_en_o        = ram_en_q;
    assign ram_we_o        = ram_we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_be_o        = ram_be_q;
    assign ram_wdata_o     = ram_wdata_q;
    assign ram_bypass_en_o = 1'b0;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0)   state_d = S_DONE;
                    else if (cmd_we_i)     state_d = S_WRITE;
                    else                   state_d = S_READ;
                end
            end
            S_WRITE: if (wr_valid_i && beats_q == LEN_WIDTH'(1)) state_d = S_DONE;
            S_READ:  if (pop && head_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        wr_ready_o  = (state_q == S_WRITE);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
    end

    // A read command issues its first request on the accept edge itself.
    always_comb begin
        addr_d      = addr_q;
        beats_d     = beats_q;
        be_d        = be_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        ram_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    be_d    = cmd_be_i;
                    addr_d  = align_addr(cmd_addr_i);
                    beats_d = cmd_len_i;
                    if (cmd_len_i != '0 && !cmd_we_i) begin
                        ram_en_d   = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = align_addr(cmd_addr_i);
                        ram_be_d   = '1;
                        ram_last_d = (cmd_len_i == LEN_WIDTH'(1));
                        addr_d     = align_addr(cmd_addr_i) + ADDR_STEP;
                        beats_d    = cmd_len_i - 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid_i) begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_be_d    = be_q;
                    ram_wdata_d = wr_data_i;
                    addr_d      = addr_q + ADDR_STEP;
                    beats_d     = beats_q - 1'b1;
                end
            end
            S_READ: begin
                if (can_issue) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = addr_q;
                    ram_be_d   = '1;
                    ram_last_d = (beats_q == LEN_WIDTH'(1));
                    addr_d     = addr_q + ADDR_STEP;
                    beats_d    = beats_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            beats_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            ram_last_q  <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_last_q  <= 1'b0;
        end else begin
            beats_q     <= beats_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            ram_last_q  <= ram_last_d;
            cap_vld_q   <= ram_en_q & ~ram_we_q;
            cap_last_q  <= ram_last_q;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        be_q   <= be_d;
    end

    // Return FIFO: storage is not reset, pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= {cap_last_q, ram_rdata_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= next_ptr(wptr_q);
            if (pop)  rptr_q <= next_ptr(rptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
